// File: rtl/wisc_alu_pkg.sv
// rtl/wisc_alu_pkg.sv - shared opcode enum and saturation constants for wisc_alu16
package wisc_alu_pkg;

   typedef enum logic [2:0] {
      ADD    = 3'd0,
      SUB    = 3'd1,
      NAND   = 3'd2,
      XOR    = 3'd3,
      PADDSB = 3'd4,
      RED    = 3'd5,
      RSV6   = 3'd6,
      RSV7   = 3'd7
   } alu_op_e;

   localparam logic [15:0] SAT_POS16 = 16'h7FFF;
   localparam logic [15:0] SAT_NEG16 = 16'h8000;
   localparam logic [3:0]  SAT_POS4  = 4'h7;
   localparam logic [3:0]  SAT_NEG4  = 4'h8;

   // 4-bit carry-lookahead slice; returns {carry_out, sum}
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      return {c[4], p ^ c[3:0]};
   endfunction

endpackage

// File: rtl/wisc_alu16_sat_addsub16.sv
// rtl/wisc_alu16_sat_addsub16.sv - shared saturating add/sub built from four CLA slices
module sat_addsub16
   import wisc_alu_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sub,
   input  logic        pad,
   output logic [15:0] sum,
   output logic [15:0] raw_sum,
   output logic        ovfl
);

   logic [15:0] b_eff;
   logic [3:0]  lane_ovfl;
   logic        ovfl16;

   assign b_eff = sub ? ~b : b;

   // In pad mode every slice restarts from the sub carry-in so lanes stay independent.
   always_comb begin
      logic       c;
      logic [4:0] slice;
      c         = sub;
      slice     = '0;
      raw_sum   = '0;
      lane_ovfl = '0;
      for (int i = 0; i < 4; i++) begin
         slice = cla4(a[4*i +: 4], b_eff[4*i +: 4], pad ? sub : c);
         c     = slice[4];
         raw_sum[4*i +: 4] = slice[3:0];
         lane_ovfl[i] = (a[4*i+3] == b_eff[4*i+3]) && (slice[3] != a[4*i+3]);
      end
   end

   assign ovfl16 = (a[15] == b_eff[15]) && (raw_sum[15] != a[15]);

   // On overflow a and b_eff share a sign, so a's sign picks the saturation rail.
   always_comb begin
      sum  = raw_sum;
      ovfl = 1'b0;
      if (pad) begin
         ovfl = |lane_ovfl;
         for (int i = 0; i < 4; i++) begin
            if (lane_ovfl[i]) begin
               sum[4*i +: 4] = a[4*i+3] ? SAT_NEG4 : SAT_POS4;
            end
         end
      end else begin
         ovfl = ovfl16;
         if (ovfl16) begin
            sum = a[15] ? SAT_NEG16 : SAT_POS16;
         end
      end
   end

endmodule

// File: rtl/wisc_alu16.sv
// rtl/wisc_alu16.sv - registered 16-bit ALU with saturating add/sub, PADDSB, RED and logic ops
module wisc_alu16
   import wisc_alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] alu_in1,
   input  logic [15:0] alu_in2,
   input  logic [2:0]  opcode,
   output logic [15:0] alu_out,
   output logic        error,
   output logic        zero,
   output logic        illegal_op,
   output logic        out_valid
);

   alu_op_e     op;
   logic        sub_sel;
   logic        pad_sel;
   logic [15:0] add_sum;
   logic [15:0] add_raw;
   logic        add_ovfl;

   logic [15:0] alu_out_q, alu_out_d;
   logic        error_q, error_d;
   logic        zero_q, zero_d;
   logic        illegal_q, illegal_d;
   logic        valid_q;

   assign op      = alu_op_e'(opcode);
   assign sub_sel = (op == SUB);
   assign pad_sel = (op == PADDSB);

   sat_addsub16 u_addsub (
      .a       (alu_in1),
      .b       (alu_in2),
      .sub     (sub_sel),
      .pad     (pad_sel),
      .sum     (add_sum),
      .raw_sum (add_raw),
      .ovfl    (add_ovfl)
   );

   always_comb begin
      alu_out_d = '0;
      error_d   = 1'b0;
      illegal_d = 1'b0;
      case (op)
         ADD, SUB, PADDSB: begin
            alu_out_d = add_sum;
            error_d   = add_ovfl;
         end
         NAND:    alu_out_d = ~(alu_in1 & alu_in2);
         XOR:     alu_out_d = alu_in1 ^ alu_in2;
         RED:     alu_out_d = add_raw;
         default: illegal_d = 1'b1;
      endcase
      zero_d = (alu_out_d == 16'h0000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out_q <= '0;
         error_q   <= 1'b0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         alu_out_q <= alu_out_d;
         error_q   <= error_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
         valid_q   <= in_valid;
      end
   end

   assign alu_out    = alu_out_q;
   assign error      = error_q;
   assign zero       = zero_q;
   assign illegal_op = illegal_q;
   assign out_valid  = valid_q;

endmodule

// File: tb/tb_wisc_alu16.sv
// tb/tb_wisc_alu16.sv - self-checking bench for wisc_alu16 with directed vectors and a random sweep
module tb_wisc_alu16;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   logic [2:0]  opcode;
   logic [15:0] alu_out;
   logic        error;
   logic        zero;
   logic        illegal_op;
   logic        out_valid;

   int asserts;
   int fails;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        err;
   } vec_t;

   wisc_alu16 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .opcode     (opcode),
      .alu_out    (alu_out),
      .error      (error),
      .zero       (zero),
      .illegal_op (illegal_op),
      .out_valid  (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sx4(input logic [3:0] x);
      return (x >= 4'd8) ? int'(x) - 16 : int'(x);
   endfunction

   function automatic int sx16(input logic [15:0] x);
      return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
   endfunction

   // Integer-arithmetic reference: signed sums clamped to the representable range.
   function automatic void ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] r, output logic e, output logic ill);
      int s;
      r = 16'h0000; e = 1'b0; ill = 1'b0;
      case (op)
         3'd0, 3'd1: begin
            s = (op == 3'd0) ? sx16(a) + sx16(b) : sx16(a) - sx16(b);
            if (s > 32767)       begin r = 16'h7FFF; e = 1'b1; end
            else if (s < -32768) begin r = 16'h8000; e = 1'b1; end
            else                 r = 16'(s);
         end
         3'd2: r = ~(a & b);
         3'd3: r = a ^ b;
         3'd4: begin
            for (int i = 0; i < 4; i++) begin
               s = sx4(a[4*i +: 4]) + sx4(b[4*i +: 4]);
               if (s > 7)       begin r[4*i +: 4] = 4'h7; e = 1'b1; end
               else if (s < -8) begin r[4*i +: 4] = 4'h8; e = 1'b1; end
               else             r[4*i +: 4] = 4'(s);
            end
         end
         3'd5: r = 16'((int'(a) + int'(b)) % 65536);
         default: ill = 1'b1;
      endcase
   endfunction

   task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      in_valid = v; opcode = op; alu_in1 = a; alu_in2 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; opcode = 3'd0; alu_in1 = '0; alu_in2 = '0;
      repeat (2) @(posedge clk);
      #1;
      asserts++;
      if ({alu_out, error, zero, illegal_op, out_valid} !== 20'h0) begin
         fails++; $display("FAIL reset_state: got out=%h err=%b z=%b ill=%b v=%b, want all 0",
                           alu_out, error, zero, illegal_op, out_valid);
      end
      @(negedge clk) rst_n = 1'b1;
      drive(1'b1, 3'd0, 16'h1234, 16'h0001);
      asserts++;
      if (alu_out !== 16'h1235 || error !== 1'b0 || out_valid !== 1'b1) begin
         fails++; $display("FAIL reset_first_add: got out=%h err=%b v=%b, want 1235 0 1", alu_out, error, out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      asserts++;
      if ({alu_out, error, zero, illegal_op, out_valid} !== 20'h0) begin
         fails++; $display("FAIL reset_async: got out=%h err=%b z=%b ill=%b v=%b, want all 0",
                           alu_out, error, zero, illegal_op, out_valid);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_directed(input string name, input vec_t tbl[$]);
      foreach (tbl[i]) begin
         drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
         asserts++;
         if (alu_out !== tbl[i].res || error !== tbl[i].err || zero !== (tbl[i].res == 16'h0)
             || illegal_op !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s[%0d]: got out=%h err=%b z=%b ill=%b v=%b, want out=%h err=%b z=%b ill=0 v=1",
                     name, i, alu_out, error, zero, illegal_op, out_valid,
                     tbl[i].res, tbl[i].err, tbl[i].res == 16'h0);
         end
      end
   endtask

   task automatic test_paddsb();
      vec_t t[$];
      t = '{'{3'd4, 16'h8009, 16'h9009, 16'h8008, 1'b1},
            '{3'd4, 16'h0FD8, 16'h0019, 16'h0FE8, 1'b1},
            '{3'd4, 16'h1111, 16'h2222, 16'h3333, 1'b0}};
      test_directed("paddsb", t);
   endtask

   task automatic test_add_sat();
      vec_t t[$];
      t = '{'{3'd0, 16'h8800, 16'h8901, 16'h8000, 1'b1},
            '{3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1},
            '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0}};
      test_directed("add_sat", t);
   endtask

   task automatic test_sub();
      vec_t t[$];
      t = '{'{3'd1, 16'h8000, 16'h0001, 16'h8000, 1'b1},
            '{3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0},
            '{3'd1, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1}};
      test_directed("sub", t);
   endtask

   task automatic test_logic_red();
      vec_t t[$];
      t = '{'{3'd2, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0},
            '{3'd3, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0},
            '{3'd5, 16'h1111, 16'h1111, 16'h2222, 1'b0},
            '{3'd5, 16'hFFFF, 16'h0002, 16'h0001, 1'b0},
            '{3'd5, 16'h7FFF, 16'h0001, 16'h8000, 1'b0}};
      test_directed("logic_red", t);
   endtask

   task automatic test_reserved();
      for (int k = 6; k < 8; k++) begin
         drive(1'b1, 3'(k), 16'hABCD, 16'h1234);
         asserts++;
         if (alu_out !== 16'h0 || error !== 1'b0 || illegal_op !== 1'b1 || zero !== 1'b1) begin
            fails++; $display("FAIL reserved_%0d: got out=%h err=%b ill=%b z=%b, want 0000 0 1 1",
                              k, alu_out, error, illegal_op, zero);
         end
      end
   endtask

   task automatic test_random_back_to_back();
      logic [15:0] er, a, b;
      logic        ee, ei, v;
      logic [2:0]  op;
      for (int n = 0; n < 1000; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = 16'($urandom);
         b  = 16'($urandom);
         if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
         v  = 1'($urandom);
         ref_alu(op, a, b, er, ee, ei);
         drive(v, op, a, b);
         asserts++;
         if (out_valid !== v || alu_out !== er || error !== ee || illegal_op !== ei || zero !== (er == 16'h0)) begin
            fails++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: got out=%h err=%b z=%b ill=%b v=%b, want out=%h err=%b z=%b ill=%b v=%b",
                     n, op, a, b, alu_out, error, zero, illegal_op, out_valid, er, ee, er == 16'h0, ei, v);
         end
         if (op == 3'd2 || op == 3'd3 || op >= 3'd5) begin
            asserts++;
            if (error !== 1'b0) begin
               fails++; $display("FAIL random_noerr[%0d] op=%0d: got err=%b, want 0", n, op, error);
            end
         end
      end
   endtask

   initial begin
      asserts = 0;
      fails   = 0;
      test_reset();
      test_paddsb();
      test_add_sat();
      test_sub();
      test_logic_red();
      test_reserved();
      test_random_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
